// File: rtl/tdm_demux_rx.sv
// tdm_demux_rx
// Serial 4-channel TDM frame receiver. A sync strobe marks the first bit of a
// frame; bits arrive channel 0 first, each channel MSB first, and are qualified
// by the en strobe. A completed frame is reordered into channel slots and
// presented on g together with a one-cycle valid pulse. A sync that arrives
// mid-frame aborts the partial frame, pulses frame_err and restarts capture
// with that bit as bit 0 of the new frame.
module tdm_demux_rx #(
    parameter int CH_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sync,
    input  logic              din,
    output logic [4*CH_W-1:0] g,
    output logic              valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int NUM_CH  = 4;
    localparam int FRAME_W = NUM_CH * CH_W;
    localparam int CNT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    // Registered state
    state_t               r_state;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [FRAME_W-1:0]   r_shift;
    logic [FRAME_W-1:0]   r_g;
    logic                 r_valid;
    logic                 r_frame_err;

    // Next-state / control decode
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [FRAME_W-1:0]   w_shift_nxt;
    logic                 w_load_g;
    logic                 w_valid_nxt;
    logic                 w_err_nxt;

    // Frame as it stands once the current bit is shifted in (wire order)
    logic [FRAME_W-1:0]   w_frame;
    // Fresh frame holding only the current bit as bit 0
    logic [FRAME_W-1:0]   w_first_bit;

    // The shift register accumulates wire order with the first bit at the MSB
    // end, so channel 0 ends up in the top slot. Reverse the slot order so
    // channel k lands at g[(k+1)*CH_W-1 : k*CH_W]; bits inside a slot are
    // already MSB-first.
    function automatic logic [FRAME_W-1:0] wire_to_slots(
        input logic [FRAME_W-1:0] wire_frame
    );
        logic [FRAME_W-1:0] slots;
        slots = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            slots[k*CH_W +: CH_W] = wire_frame[(NUM_CH-1-k)*CH_W +: CH_W];
        end
        return slots;
    endfunction

    assign w_frame     = {r_shift[FRAME_W-2:0], din};
    assign w_first_bit = {{(FRAME_W-1){1'b0}}, din};

    // Next-state, counter, shift-register and pulse decode for one strobe
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_load_g    = 1'b0;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;

        if (en) begin
            unique case (r_state)
                HUNT: begin
                    // Data without a frame marker is not aligned; drop it.
                    if (sync) begin
                        w_shift_nxt = w_first_bit;
                        w_cnt_nxt   = CNT_ONE;
                        w_state_nxt = RECV;
                    end
                end
                RECV: begin
                    if (sync) begin
                        // Early marker: abandon the partial frame and treat
                        // this bit as the start of a new one. g is untouched.
                        w_shift_nxt = w_first_bit;
                        w_cnt_nxt   = CNT_ONE;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = RECV;
                    end else if (r_bit_cnt == CNT_LAST) begin
                        // Last bit: publish the whole frame on this edge.
                        w_shift_nxt = w_frame;
                        w_cnt_nxt   = '0;
                        w_load_g    = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = HUNT;
                    end else begin
                        w_shift_nxt = w_frame;
                        w_cnt_nxt   = r_bit_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // FSM state and bit counter; reset returns to HUNT and silently drops any partial frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= HUNT;
            r_bit_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_cnt_nxt;
        end
    end

    // Shift register collecting serial bits in wire order
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift <= '0;
        end else begin
            r_shift <= w_shift_nxt;
        end
    end

    // Output frame register, loaded only when a frame completes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_g <= '0;
        end else if (w_load_g) begin
            r_g <= wire_to_slots(w_frame);
        end
    end

    // One-cycle status pulses; the decode never raises both together
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_err_nxt;
        end
    end

    assign g         = r_g;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state == RECV);

endmodule
